alu_issue_ctrl: RTL
===================

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 Parameter BITS, default 8, datapath width of the register file and the ALU operands.
REQ-002 Parameter NREGS, default 4, number of general registers, fixed at 4 (2-bit index).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 instr  input  16  instruction: op[15:13], imm_sel[12], rd[11:10], rs1[9:8], rs2[1:0] when imm_sel=0, imm[7:0] when imm_sel=1.
REQ-006 instr_valid  input  1  instr is valid this cycle.
REQ-007 instr_ready  output  1  block can accept an instruction; high only in IDLE.
REQ-008 alu_a  output  BITS  registered A operand to the ALU.
REQ-009 alu_b  output  BITS  registered B operand to the ALU, either register rs2 or imm.
REQ-010 alu_opcode  output  3  registered ALU operation code.
REQ-011 alu_r  input  BITS  combinational ALU result.
REQ-012 alu_zero  input  1  combinational ALU zero flag.
REQ-013 done  output  1  one-cycle pulse when an instruction retires.
REQ-014 err  output  1  one-cycle pulse, together with done, when the retired opcode was illegal.
REQ-015 result  output  BITS  value written back by the last legal instruction, held until the next writeback.
REQ-016 zflag  output  1  zero flag captured by the last legal instruction.
REQ-017 dbg_sel  input  2  debug register index.
REQ-018 dbg_data  output  BITS  combinational read of register dbg_sel.

Function
REQ-019 FSM states: IDLE, OPER, EXEC, DONE; encoding in the shared package.
REQ-020 IDLE: instr_ready=1; on instr_valid=1, latch instr and go to OPER; otherwise stay in IDLE.
REQ-021 OPER: register alu_a=reg[rs1], alu_b=(imm_sel ? imm : reg[rs2]), alu_opcode=op; go to EXEC.
REQ-022 EXEC: alu outputs are settled; if op is legal (000 ADD, 001 SUB, 010 AND, 011 OR, 101 SLT), write alu_r to reg[rd], result and alu_zero to zflag; go to DONE.
REQ-023 EXEC with illegal op (100, 110, 111): no register, result or zflag write; set pending error; go to DONE.
REQ-024 DONE: done=1 for exactly one cycle, err=1 in the same cycle if the op was illegal; go to IDLE.
REQ-025 Latency: an instruction accepted at edge N retires with done high in cycle N+3; throughput one instruction per 4 cycles.
REQ-026 instr and instr_valid are ignored outside IDLE; no queuing.
REQ-027 Operands are read in OPER; a write by the previous instruction (in EXEC) is visible to the next, because the next OPER occurs at least 2 cycles later.
REQ-028 rd may equal rs1 or rs2; the read uses the old value and the write takes place in EXEC.
REQ-029 All register indices wrap within 0..3; every register, including r0, is writable.
REQ-030 Arithmetic is modulo 2^BITS; no carry or overflow output.
REQ-031 dbg_data reflects a write on the cycle after EXEC.

Reset
REQ-032 rst=1 at a clock edge forces IDLE, all registers to 0, alu_a=alu_b=0, alu_opcode=000, result=0, zflag=0, done=err=0.
REQ-033 rst during OPER, EXEC or DONE aborts the instruction: no writeback, and no done or err pulse.
REQ-034 instr_ready is 0 while rst=1 and is 1 in the first cycle after rst is released.

Structure
REQ-035 A shared package alu_pkg holds BITS, the ALU opcode constants (ADD, SUB, AND, OR, SLT) and the FSM state encoding; the ALU and this block both use it.
REQ-036 The register file is a sub-module regfile_4x8 with 2 combinational read ports, 1 debug read port, 1 synchronous write port and synchronous reset.
REQ-037 The ALU is instantiated outside this block; the testbench instantiates the ALU and connects it through alu_a, alu_b, alu_opcode, alu_r and alu_zero.

Verification
REQ-038 Reset, then ADD imm: r1=r0+0x05 -> done at N+3, result=0x05, zflag=0, dbg r1=0x05.
REQ-039 Back-to-back dependent instructions: r2=r1+0x0B then r3=r2-r2 -> r2=0x10, then r3=0x00, zflag=1.
REQ-040 Wrap and SLT: r1=0xFF, r1+0x01 -> 0x00 with zflag=1; SLT r1=0x03<0x07 -> result=0x01.
REQ-041 Illegal op 110 -> done and err high in the same cycle; registers, result and zflag unchanged.
REQ-042 instr_valid held high during OPER, EXEC and DONE -> only one instruction is accepted; instr_ready pattern is 1,0,0,0,1.
REQ-043 rst asserted in EXEC -> no done pulse; all registers read 0; IDLE in the cycle after rst is released.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared datapath width, ALU opcodes and issue FSM encoding
package alu_pkg;

  localparam int BITS = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPER = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU driven by the issue controller
module alu
  import alu_pkg::*;
#(
  parameter int BITS = alu_pkg::BITS
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic [2:0]      op,
  output logic [BITS-1:0] r,
  output logic            zero
);

  always_comb begin
    r = '0;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      // signed compare, result is 0 or 1
      OP_SLT:  r = BITS'($signed(a) < $signed(b));
      default: r = '0;
    endcase
    zero = (r == '0);
  end

endmodule

// File: rtl/regfile_4x8.sv
// rtl/regfile_4x8.sv - register file, two operand read ports, debug read, one write port
module regfile_4x8 #(
  parameter int BITS  = 8,
  parameter int NREGS = 4,
  localparam int IW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [IW-1:0]   waddr,
  input  logic [BITS-1:0] wdata,
  input  logic [IW-1:0]   raddr1,
  input  logic [IW-1:0]   raddr2,
  input  logic [IW-1:0]   dbg_sel,
  output logic [BITS-1:0] rdata1,
  output logic [BITS-1:0] rdata2,
  output logic [BITS-1:0] dbg_data
);

  logic [BITS-1:0] regs_q [NREGS];
  logic [BITS-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata1   = regs_q[raddr1];
  assign rdata2   = regs_q[raddr2];
  assign dbg_data = regs_q[dbg_sel];

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - single-issue controller: latch, read operands, execute, retire
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int BITS  = alu_pkg::BITS,
  parameter int NREGS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [15:0]     instr,
  input  logic            instr_valid,
  output logic            instr_ready,
  output logic [BITS-1:0] alu_a,
  output logic [BITS-1:0] alu_b,
  output logic [2:0]      alu_opcode,
  input  logic [BITS-1:0] alu_r,
  input  logic            alu_zero,
  output logic            done,
  output logic            err,
  output logic [BITS-1:0] result,
  output logic            zflag,
  input  logic [1:0]      dbg_sel,
  output logic [BITS-1:0] dbg_data
);

  state_e          state_q, state_d;
  logic [15:0]     instr_q, instr_d;
  logic [BITS-1:0] alu_a_q, alu_a_d;
  logic [BITS-1:0] alu_b_q, alu_b_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic [BITS-1:0] result_q, result_d;
  logic            zflag_q, zflag_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            rf_we;
  logic [BITS-1:0] rs1_data, rs2_data;

  wire [2:0] op_f    = instr_q[15:13];
  wire       imm_sel = instr_q[12];

  regfile_4x8 #(
    .BITS  (BITS),
    .NREGS (NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (instr_q[11:10]),
    .wdata    (alu_r),
    .raddr1   (instr_q[9:8]),
    .raddr2   (instr_q[1:0]),
    .dbg_sel  (dbg_sel),
    .rdata1   (rs1_data),
    .rdata2   (rs2_data),
    .dbg_data (dbg_data)
  );

  always_comb begin
    state_d  = state_q;
    instr_d  = instr_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    alu_op_d = alu_op_q;
    result_d = result_q;
    zflag_d  = zflag_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rf_we    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_OPER;
        end
      end
      ST_OPER: begin
        alu_a_d  = rs1_data;
        alu_b_d  = imm_sel ? BITS'(instr_q[7:0]) : rs2_data;
        alu_op_d = op_f;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        // illegal ops retire with err and leave all architectural state alone
        if (op_legal(op_f)) begin
          rf_we    = 1'b1;
          result_d = alu_r;
          zflag_d  = alu_zero;
        end else begin
          err_d = 1'b1;
        end
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      instr_q  <= '0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= OP_ADD;
      result_q <= '0;
      zflag_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      alu_a_q  <= alu_a_d;
      alu_b_q  <= alu_b_d;
      alu_op_q <= alu_op_d;
      result_q <= result_d;
      zflag_q  <= zflag_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign instr_ready = (state_q == ST_IDLE) && !rst;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = alu_op_q;
  assign result      = result_q;
  assign zflag       = zflag_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule
